rggen_apb_request_bridge: RTL

RGGEN_APB_REQUEST_BRIDGE -- requirements
Module: rggen_apb_request_bridge

---
 rtl/rggen_apb_request_bridge_if.sv | 24 ++
 rtl/rggen_apb_request_bridge.sv | 93 +++++++++
 2 files changed

// File: rtl/rggen_apb_request_bridge_if.sv
// rggen_apb_if: APB bus bundle shared by the request bridge and its slave.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;
  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );
  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_request_bridge.sv
// rggen_apb_request_bridge: turns a valid/ready request into one APB transfer, with optional access timeout.
module rggen_apb_request_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [BUS_WIDTH-1:0]     i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  rggen_apb_if.master              apb_if
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_e;
  state_e                   r_state;
  state_e                   w_next;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0]     r_wdata;
  logic [BUS_WIDTH/8-1:0]   r_strb;
  logic [BUS_WIDTH-1:0]     r_rdata;
  logic [1:0]               r_status;
  logic                     w_accept;
  logic                     w_timeout;
  logic                     w_done;
  assign o_req_ready    = r_state == IDLE;
  assign o_rsp_valid    = r_state == RESPONSE;
  assign w_accept       = i_req_valid && o_req_ready;
  assign w_done         = r_state == ACCESS && (apb_if.pready || w_timeout);
  assign apb_if.psel    = r_state == SETUP || r_state == ACCESS;
  assign apb_if.penable = r_state == ACCESS;
  assign apb_if.paddr   = r_addr;
  assign apb_if.pprot   = 3'b000;
  assign apb_if.pwrite  = r_write;
  assign apb_if.pstrb   = r_strb;
  assign apb_if.pwdata  = r_wdata;
  assign o_rsp_read_data = r_rdata;
  assign o_rsp_status    = r_status;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_accept ? SETUP : IDLE;
      SETUP:    w_next = ACCESS;
      ACCESS:   w_next = w_done ? RESPONSE : ACCESS;
      RESPONSE: w_next = i_rsp_ready ? IDLE : RESPONSE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_rdata  <= '0;
      r_status <= 2'b00;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_address;
        r_wdata <= i_req_write_data;
        r_strb  <= i_req_write ? i_req_strobe : '0;
      end
      if (w_done) begin
        r_status <= apb_if.pready ? {apb_if.pslverr, 1'b0} : 2'b11;
        r_rdata  <= (apb_if.pready && !apb_if.pslverr && !r_write) ? apb_if.prdata : '0;
      end
    end
  end
  // The counter holds the number of ACCESS cycles already spent waiting.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_count;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_count <= '0;
      else if (r_state == SETUP) r_count <= '0;
      else if (r_state == ACCESS && !apb_if.pready) r_count <= r_count + 1'b1;
    end
    assign w_timeout = r_state == ACCESS && !apb_if.pready && r_count == CW'(TIMEOUT_CYCLES - 1);
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end
endmodule
